// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge
// Converts a valid/ready command stream into single APB4 transfers and returns
// one response per command. One transfer is in flight at a time.
//
// Build option:
//   APB_MASTER_TIMEOUT_EN - when defined, an ACCESS phase that sees PREADY low
//                           for TIMEOUT_CYCLES cycles is abandoned and answered
//                           with an error response. When undefined, ACCESS
//                           waits for PREADY indefinitely.
//
// Reset: rst is asynchronous and active-low.

module apb4_master_bridge #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    // command channel
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,

    // response channel
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,

    // APB4 requester
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Reject configurations the datapath and the 8-bit timeout counter cannot handle.
    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
        $error("apb4_master_bridge: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic                    accept;    // command handshake this cycle
    logic                    complete;  // slave finished the ACCESS phase this cycle
    logic                    timeout;   // ACCESS abandoned this cycle

    logic                    write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   strb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0]   TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]              tmo_cnt;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle event strobes.
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        complete  = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    complete  = 1'b1;
                    state_nxt = ST_RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command capture and response capture.
    // NOTE: the datapath registers are reset because their values drive
    // primary outputs that must read zero while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                // reads present zero write data and zero strobes on the bus
                wdata_q <= cmd_write ? cmd_wdata : '0;
                strb_q  <= cmd_write ? cmd_strb  : '0;
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
            if (complete) begin
                err_q   <= pslverr;
                // only a successful read returns data
                rdata_q <= (!write_q && !pslverr) ? prdata : '0;
            end
            if (timeout) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Count stalled ACCESS cycles; restarts at every SETUP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == ST_SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ST_ACCESS && !pready && !timeout) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`endif

    // Handshake and bus control decode straight from state, so an asserted
    // reset removes psel/penable immediately through the async state reset.
    assign cmd_ready = rst && (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign psel      = (state == ST_SETUP) || (state == ST_ACCESS);
    assign penable   = (state == ST_ACCESS);

    // Bus payload comes from the command registers, stable from SETUP to the end of ACCESS.
    assign paddr     = addr_q;
    assign pwrite    = write_q;
    assign pwdata    = wdata_q;
    assign pstrb     = strb_q;
    assign pprot     = 3'b000;

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Directed self-checking bench for apb4_master_bridge (default parameters).
// Inputs change and outputs are sampled 1 time unit after the rising edge.

module tb_apb4_master_bridge;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    apb4_master_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .pprot     (pprot),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer: accept, SETUP, stall+1 ACCESS cycles, RESP held for
    // hold cycles (with cmd_valid raised meanwhile), then the response handshake.
    task automatic run_txn(input string name, input logic wr, input logic [2:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int stall, input logic [31:0] rd, input logic err,
                           input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        exp_pwdata = wr ? wdata : 32'h0;
        exp_pstrb  = wr ? strb  : 4'h0;

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        rsp_ready = 1'b0;
        // noise on the slave inputs outside ACCESS must be ignored
        pready    = 1'b1;
        pslverr   = 1'b1;
        prdata    = 32'hA5A5A5A5;
        check({name, " idle cmd_ready"}, cmd_ready, 1);
        check({name, " idle psel"}, psel, 0);
        step();

        // SETUP; scramble the command inputs to prove the bus uses captured values
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        cmd_strb  = ~strb;
        pready    = 1'b0;
        check({name, " setup psel"}, psel, 1);
        check({name, " setup penable"}, penable, 0);
        check({name, " setup paddr"}, paddr, addr);
        check({name, " setup pwrite"}, pwrite, wr);
        check({name, " setup pwdata"}, pwdata, exp_pwdata);
        check({name, " setup pstrb"}, pstrb, exp_pstrb);
        check({name, " setup cmd_ready"}, cmd_ready, 0);
        step();

        for (int i = 0; i <= stall; i++) begin
            pready  = (i == stall);
            pslverr = (i == stall) ? err : 1'b1;
            prdata  = (i == stall) ? rd : 32'hA5A5A5A5;
            check({name, " access psel"}, psel, 1);
            check({name, " access penable"}, penable, 1);
            check({name, " access paddr"}, paddr, addr);
            check({name, " access pwrite"}, pwrite, wr);
            check({name, " access pwdata"}, pwdata, exp_pwdata);
            check({name, " access pstrb"}, pstrb, exp_pstrb);
            check({name, " access rsp_valid"}, rsp_valid, 0);
            step();
        end

        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h5A5A5A5A;
        for (int k = 0; k < hold; k++) begin
            cmd_valid = 1'b1;
            check({name, " hold rsp_valid"}, rsp_valid, 1);
            check({name, " hold rsp_rdata"}, rsp_rdata, exp_rdata);
            check({name, " hold rsp_err"}, rsp_err, exp_err);
            check({name, " hold cmd_ready"}, cmd_ready, 0);
            check({name, " hold psel"}, psel, 0);
            step();
        end

        rsp_ready = 1'b1;
        check({name, " resp rsp_valid"}, rsp_valid, 1);
        check({name, " resp rsp_rdata"}, rsp_rdata, exp_rdata);
        check({name, " resp rsp_err"}, rsp_err, exp_err);
        check({name, " resp psel"}, psel, 0);
        check({name, " resp penable"}, penable, 0);
        check({name, " resp cmd_ready"}, cmd_ready, 0);
        step();

        rsp_ready = 1'b0;
        check({name, " done rsp_valid"}, rsp_valid, 0);
        check({name, " done cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;

        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst cmd_ready", cmd_ready, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_err", rsp_err, 0);
        check("rst rsp_rdata", rsp_rdata, 0);
        check("rst psel", psel, 0);
        check("rst penable", penable, 0);
        check("rst pwrite", pwrite, 0);
        check("rst paddr", paddr, 0);
        check("rst pwdata", pwdata, 0);
        check("rst pstrb", pstrb, 0);
        check("rst pprot", pprot, 0);
        rst = 1'b1;
        #1;
        check("post-rst cmd_ready", cmd_ready, 1);

        // write, zero wait states; rdata must stay 0 despite prdata noise
        run_txn("wr0", 1'b1, 3'h4, 32'hDEADBEEF, 4'hF, 0, 32'h11112222, 1'b0, 32'h0, 1'b0, 0);
        // read, three wait states; write data/strobes on the bus must be zero
        run_txn("rd3", 1'b0, 3'h0, 32'hCAFEF00D, 4'hF, 3, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 0);
        // read with slave error; response held back 5 cycles with a new command waiting
        run_txn("rderr", 1'b0, 3'h5, 32'h0, 4'h0, 1, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1, 5);
        // the waiting command is accepted right after the handshake: partial-strobe write with error
        run_txn("wrerr", 1'b1, 3'h7, 32'h55AA00FF, 4'h3, 0, 32'h99999999, 1'b1, 32'h0, 1'b1, 0);
        // read, zero wait states
        run_txn("rd0", 1'b0, 3'h2, 32'h0, 4'h0, 0, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 1'b0, 0);

        // reset asserted during ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 3'h6;
        pready    = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        check("mid access psel", psel, 1);
        check("mid access penable", penable, 1);
        #2 rst = 1'b0;
        #1;
        check("async rst psel", psel, 0);
        check("async rst penable", penable, 0);
        check("async rst cmd_ready", cmd_ready, 0);
        check("async rst paddr", paddr, 0);
        step();
        rst = 1'b1;
        #1;
        check("rel cmd_ready", cmd_ready, 1);
        check("rel rsp_valid", rsp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rel idle rsp_valid", rsp_valid, 0);
            check("rel idle psel", psel, 0);
            check("rel idle cmd_ready", cmd_ready, 1);
        end

        // bridge works normally after the reset
        run_txn("wr_after_rst", 1'b1, 3'h1, 32'h01234567, 4'h9, 2, 32'h0, 1'b0, 32'h0, 1'b0, 0);

`ifdef APB_MASTER_TIMEOUT_EN
        begin
            int n_access;
            n_access  = 0;
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = 3'h3;
            pready    = 1'b0;
            step();
            cmd_valid = 1'b0;
            step();
            while (psel && n_access < 40) begin
                n_access++;
                step();
            end
            check("tmo access cycles", n_access, 16);
            check("tmo rsp_valid", rsp_valid, 1);
            check("tmo rsp_err", rsp_err, 1);
            check("tmo rsp_rdata", rsp_rdata, 0);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            check("tmo done cmd_ready", cmd_ready, 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
